// File: rtl/pipe_hazard_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_if
//   Bundle between the ID stage / datapath and the hazard + forwarding unit.
//
//   master : pipeline side. Drives the ID instruction fields, the register-file
//            read data, the per-slot writeback values and the EX jump. Receives
//            stall/flush, the resolved operands and the forwarding selects.
//   slave  : pipe_hazard_unit side, with the opposite directions.
//
//   Signals
//     id_valid_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
//     id_rd_i, id_we_i, id_load_i    : ID-stage instruction fields
//     rf_rd1_i, rf_rd2_i             : register-file read data
//     stage_data_i                   : writeback value per slot, slot k at [k*XLEN +: XLEN]
//     ex_jump_i                      : taken branch/jump resolved in EX
//     stall_o, flush_o               : pipeline control
//     op1_o, op2_o                   : resolved source operands
//     fwd1_sel_o, fwd2_sel_o         : 0 = register file, k+1 = slot k
// ----------------------------------------------------------------------------
interface pipe_hazard_if #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int FWD_DEPTH = 3
);
  logic                      id_valid_i;
  logic [RA_W-1:0]           id_rs1_i;
  logic [RA_W-1:0]           id_rs2_i;
  logic                      id_rs1_re_i;
  logic                      id_rs2_re_i;
  logic [RA_W-1:0]           id_rd_i;
  logic                      id_we_i;
  logic                      id_load_i;
  logic [XLEN-1:0]           rf_rd1_i;
  logic [XLEN-1:0]           rf_rd2_i;
  logic [FWD_DEPTH*XLEN-1:0] stage_data_i;
  logic                      ex_jump_i;
  logic                      stall_o;
  logic                      flush_o;
  logic [XLEN-1:0]           op1_o;
  logic [XLEN-1:0]           op2_o;
  logic [3:0]                fwd1_sel_o;
  logic [3:0]                fwd2_sel_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
           id_rd_i, id_we_i, id_load_i, rf_rd1_i, rf_rd2_i,
           stage_data_i, ex_jump_i,
    input  stall_o, flush_o, op1_o, op2_o, fwd1_sel_o, fwd2_sel_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
           id_rd_i, id_we_i, id_load_i, rf_rd1_i, rf_rd2_i,
           stage_data_i, ex_jump_i,
    output stall_o, flush_o, op1_o, op2_o, fwd1_sel_o, fwd2_sel_o
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// ----------------------------------------------------------------------------
// pipe_hazard_unit
//   Hazard / forwarding controller for the in-order RV32 pipeline. Tracks the
//   destination register of every instruction past ID in a shift-register
//   scoreboard (slot 0 = EX ... slot FWD_DEPTH-1 = WB) and from it derives
//   load-use stalls, per-operand forwarding selects/data and the branch flush.
//
//   Parameters
//     XLEN      datapath width
//     RA_W      register address width
//     FWD_DEPTH tracked post-ID stages (2..8)
//     LOAD_LAT  first slot where load data is valid (0..FWD_DEPTH-1)
//     FWD_EN    1 = full forwarding, 0 = interlock, forward from WB only
//
//   Ports
//     clk, rst  clock, asynchronous active-high reset
//     hz        pipe_hazard_if.slave (ID fields, rf data, stage data, jump in;
//               stall, flush, operands, selects out)
//     perf_stall_o / perf_flush_o / perf_fwd_o
//               saturating event counters, present only when the macro
//               HAZ_PERF_CNT_EN is defined
// ----------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FWD_EN    = 1
) (
  input  logic         clk,
  input  logic         rst,
  pipe_hazard_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]  perf_stall_o,
  output logic [31:0]  perf_flush_o,
  output logic [31:0]  perf_fwd_o
`endif
);

  // A load in slot k has its data in stage_data_i once k reaches LOAD_LAT.
  function automatic logic slot_ready(input logic ld, input int k);
    return !ld || (k >= LOAD_LAT);
  endfunction

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction
`endif

  // Scoreboard: valid bits are control (reset), rd/ld are payload (not reset).
  logic [FWD_DEPTH-1:0] slot_v;
  logic [FWD_DEPTH-1:0] slot_ld;
  logic [RA_W-1:0]      slot_rd [FWD_DEPTH];

  logic [RA_W-1:0]      src    [2];
  logic                 src_re [2];
  logic [XLEN-1:0]      rf_d   [2];
  logic [FWD_DEPTH-1:0] match  [2];
  logic [3:0]           sel    [2];
  logic [XLEN-1:0]      op     [2];
  logic                 op_stall [2];
  logic                 stall;
  logic                 issue;

  assign src[0]    = hz.id_rs1_i;
  assign src[1]    = hz.id_rs2_i;
  assign src_re[0] = hz.id_rs1_re_i;
  assign src_re[1] = hz.id_rs2_re_i;
  assign rf_d[0]   = hz.rf_rd1_i;
  assign rf_d[1]   = hz.rf_rd2_i;

  // ---- ID stage: scoreboard compare ----
  // x0 never matches, so reads of x0 always take the (zero) regfile value.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      match[s] = '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        match[s][k] = slot_v[k] && (slot_rd[k] != '0) &&
                      (slot_rd[k] == src[s]) && src_re[s];
      end
    end
  end

  // Operand resolution. The loop runs oldest to youngest so the youngest
  // matching slot overwrites any older one.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      sel[s]      = '0;
      op[s]       = rf_d[s];
      op_stall[s] = 1'b0;
      if (FWD_EN != 0) begin
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
          if (match[s][k]) begin
            if (slot_ready(slot_ld[k], k)) begin
              sel[s]      = 4'(k + 1);
              op[s]       = hz.stage_data_i[k*XLEN +: XLEN];
              op_stall[s] = 1'b0;
            end else begin
              sel[s]      = '0;
              op[s]       = rf_d[s];
              op_stall[s] = 1'b1;
            end
          end
        end
      end else begin
        if (|match[s][FWD_DEPTH-2:0]) begin
          op_stall[s] = 1'b1;
        end else if (match[s][FWD_DEPTH-1]) begin
          sel[s] = 4'(FWD_DEPTH);
          op[s]  = hz.stage_data_i[(FWD_DEPTH-1)*XLEN +: XLEN];
        end
      end
    end
  end

  // A jump in EX kills the ID instruction, so it must not also stall.
  assign stall = hz.id_valid_i && !hz.ex_jump_i && (op_stall[0] || op_stall[1]);
  assign issue = hz.id_valid_i && !hz.ex_jump_i && !stall;

  assign hz.stall_o    = stall;
  assign hz.flush_o    = hz.ex_jump_i;
  assign hz.op1_o      = op[0];
  assign hz.op2_o      = op[1];
  assign hz.fwd1_sel_o = sel[0];
  assign hz.fwd2_sel_o = sel[1];

  // ---- EX..WB: scoreboard shift ----
  // The shift never holds: a stalled load keeps moving toward readiness while
  // a bubble enters slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v <= '0;
    end else begin
      slot_v <= {slot_v[FWD_DEPTH-2:0], issue && hz.id_we_i};
    end
  end

  always_ff @(posedge clk) begin
    slot_ld    <= {slot_ld[FWD_DEPTH-2:0], hz.id_load_i};
    slot_rd[0] <= hz.id_rd_i;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      slot_rd[k] <= slot_rd[k-1];
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic fwd_evt;
  assign fwd_evt = ((sel[0] != '0) || (sel[1] != '0)) && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_o <= '0;
      perf_flush_o <= '0;
      perf_fwd_o   <= '0;
    end else begin
      if (stall)         perf_stall_o <= sat_inc(perf_stall_o);
      if (hz.ex_jump_i)  perf_flush_o <= sat_inc(perf_flush_o);
      if (fwd_evt)       perf_fwd_o   <= sat_inc(perf_fwd_o);
    end
  end
`endif

endmodule
